// File: rtl/tmds_decoder.sv
// tmds_decoder: receive-side TMDS channel decoder for one data channel.
// Takes unaligned 10-bit words from a 1:10 deserializer, finds word alignment
// with a bitslip search on control tokens, and decodes aligned words into
// pixel data, control bits and data enable.
//
// Ports:
//   clkPixel    pixel clock, one 10-bit word per cycle
//   nreset      asynchronous active-low reset
//   rawWord     unaligned deserializer word, bit 0 earliest
//   dataOut     decoded pixel byte (valid while de=1)
//   c0, c1      decoded control bits
//   de          data enable
//   locked      word alignment achieved
//   slipPos     current bit offset 0..9
//   terc4       decoded TERC4 nibble
//   terc4Valid  TERC4 code matched
//
// Build option: define TMDS_DEC_TERC4_EN to enable TERC4 code matching;
// without it terc4/terc4Valid are tied to zero.
module tmds_decoder #(
    parameter int unsigned SEARCH_BITS = 12,
    parameter int unsigned LOCK_COUNT  = 32
) (
    input  logic       clkPixel,
    input  logic       nreset,
    input  logic [9:0] rawWord,
    output logic [7:0] dataOut,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       locked,
    output logic [3:0] slipPos,
    output logic [3:0] terc4,
    output logic       terc4Valid
);

    localparam int unsigned WORD_W   = 10;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SLIP_W   = 4;
    localparam int unsigned SETTLE_W = 2;

    localparam logic [CNT_W-1:0]    LOCK_TARGET  = CNT_W'(LOCK_COUNT);
    localparam logic [SLIP_W-1:0]   SLIP_LAST    = SLIP_W'(9);
    localparam logic [SETTLE_W-1:0] SETTLE_WORDS = SETTLE_W'(2);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [WORD_W-1:0]      raw_prev_q;
    logic [WORD_W-1:0]      stage1_q;
    logic [2*WORD_W-1:0]    window_c;
    logic [WORD_W-1:0]      aligned_c;
    logic [SEARCH_BITS-1:0] timer_q;
    logic [SEARCH_BITS-1:0] timer_d;
    logic [CNT_W-1:0]       tok_cnt_q;
    logic [CNT_W-1:0]       tok_cnt_d;
    logic [SETTLE_W-1:0]    settle_q;
    logic [SETTLE_W-1:0]    settle_d;
    logic [SLIP_W-1:0]      slip_d;
    logic                   slip_step_c;
    logic                   is_token_c;
    logic [1:0]             token_val_c;
    logic [DATA_W-1:0]      data_c;
    logic [DATA_W-1:0]      q_c;

    // Stage 1: select the aligned word out of the previous+current raw words
    assign window_c  = {rawWord, raw_prev_q};
    assign aligned_c = WORD_W'(window_c >> slipPos);

    always_ff @(posedge clkPixel or negedge nreset) begin
        if (!nreset) begin
            raw_prev_q <= '0;
            stage1_q   <= '0;
        end else begin
            raw_prev_q <= rawWord;
            stage1_q   <= aligned_c;
        end
    end

    // Control token detection on the aligned word
    always_comb begin
        is_token_c  = 1'b1;
        token_val_c = 2'b00;
        case (stage1_q)
            10'b1101010100: token_val_c = 2'b00;
            10'b0010101011: token_val_c = 2'b01;
            10'b0101010100: token_val_c = 2'b10;
            10'b1010101011: token_val_c = 2'b11;
            default:        is_token_c  = 1'b0;
        endcase
    end

    // TMDS data decode: undo optional inversion, then XOR/XNOR chain
    always_comb begin
        q_c       = stage1_q[9] ? ~stage1_q[7:0] : stage1_q[7:0];
        data_c    = '0;
        data_c[0] = q_c[0];
        for (int i = 1; i < int'(DATA_W); i++) begin
            data_c[i] = stage1_q[8] ? (q_c[i] ^ q_c[i-1]) : ~(q_c[i] ^ q_c[i-1]);
        end
    end

    // Alignment FSM state registers
    always_ff @(posedge clkPixel or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_SEARCH;
            timer_q   <= '0;
            tok_cnt_q <= '0;
            settle_q  <= '0;
            slipPos   <= '0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tok_cnt_q <= tok_cnt_d;
            settle_q  <= settle_d;
            slipPos   <= slip_d;
            locked    <= (state_d == ST_LOCKED);
        end
    end

    // Alignment FSM next state; settle words after a slip are skipped entirely
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        tok_cnt_d   = tok_cnt_q;
        settle_d    = settle_q;
        slip_d      = slipPos;
        slip_step_c = 1'b0;

        if (settle_q != '0) begin
            settle_d = settle_q - SETTLE_W'(1);
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    // a token beats a simultaneous timer wrap
                    if (is_token_c) begin
                        tok_cnt_d = CNT_W'(1);
                        timer_d   = '0;
                        state_d   = (LOCK_TARGET <= CNT_W'(1)) ? ST_LOCKED : ST_VERIFY;
                    end else begin
                        timer_d = timer_q + SEARCH_BITS'(1);
                        if (timer_q == '1) begin
                            slip_step_c = 1'b1;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (is_token_c) begin
                        if (tok_cnt_q >= LOCK_TARGET - CNT_W'(1)) begin
                            tok_cnt_d = LOCK_TARGET;
                            state_d   = ST_LOCKED;
                        end else begin
                            tok_cnt_d = tok_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d   = ST_SEARCH;
                        timer_d   = '0;
                        tok_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (is_token_c) begin
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + SEARCH_BITS'(1);
                        if (timer_q == '1) begin
                            state_d     = ST_SEARCH;
                            tok_cnt_d   = '0;
                            slip_step_c = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = ST_SEARCH;
                    timer_d   = '0;
                    tok_cnt_d = '0;
                end
            endcase
        end

        if (slip_step_c) begin
            slip_d   = (slipPos == SLIP_LAST) ? '0 : slipPos + SLIP_W'(1);
            settle_d = SETTLE_WORDS;
        end
    end

    // Stage 2: decoded outputs follow the lock state being entered this edge
    always_ff @(posedge clkPixel or negedge nreset) begin
        if (!nreset) begin
            dataOut <= '0;
            c0      <= 1'b0;
            c1      <= 1'b0;
            de      <= 1'b0;
        end else if (state_d == ST_LOCKED) begin
            if (is_token_c) begin
                de <= 1'b0;
                c0 <= token_val_c[0];
                c1 <= token_val_c[1];
            end else begin
                de      <= 1'b1;
                dataOut <= data_c;
            end
        end else begin
            dataOut <= '0;
            c0      <= 1'b0;
            c1      <= 1'b0;
            de      <= 1'b0;
        end
    end

`ifdef TMDS_DEC_TERC4_EN
    logic       terc4_hit_c;
    logic [3:0] terc4_val_c;

    // TERC4 code match, flag only; independent of lock and data path
    always_comb begin
        terc4_hit_c = 1'b1;
        terc4_val_c = 4'd0;
        case (stage1_q)
            10'b1010011100: terc4_val_c = 4'd0;
            10'b1001100011: terc4_val_c = 4'd1;
            10'b1011100100: terc4_val_c = 4'd2;
            10'b1011100010: terc4_val_c = 4'd3;
            10'b0101110001: terc4_val_c = 4'd4;
            10'b0100011110: terc4_val_c = 4'd5;
            10'b0110001110: terc4_val_c = 4'd6;
            10'b0100111100: terc4_val_c = 4'd7;
            10'b1011001100: terc4_val_c = 4'd8;
            10'b0100111001: terc4_val_c = 4'd9;
            10'b0110011100: terc4_val_c = 4'd10;
            10'b1011000110: terc4_val_c = 4'd11;
            10'b1010001110: terc4_val_c = 4'd12;
            10'b1001110001: terc4_val_c = 4'd13;
            10'b0101100011: terc4_val_c = 4'd14;
            10'b1011000011: terc4_val_c = 4'd15;
            default:        terc4_hit_c = 1'b0;
        endcase
    end

    always_ff @(posedge clkPixel or negedge nreset) begin
        if (!nreset) begin
            terc4      <= '0;
            terc4Valid <= 1'b0;
        end else begin
            terc4      <= terc4_hit_c ? terc4_val_c : 4'd0;
            terc4Valid <= terc4_hit_c;
        end
    end
`else
    assign terc4      = 4'd0;
    assign terc4Valid = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: self-checking bench for tmds_decoder.
// A behavioural reference (token/TERC4 lookup, arithmetic decode, slip search
// rules) predicts every output each cycle; literal checks pin key points.
module tb_tmds_decoder;

    localparam int SEARCH_BITS = 12;
    localparam int LOCK_COUNT  = 32;
    localparam int TIMEOUT     = 1 << SEARCH_BITS;
    localparam int M_SEARCH    = 0;
    localparam int M_VERIFY    = 1;
    localparam int M_LOCKED    = 2;

    logic       clkPixel = 1'b0;
    logic       nreset;
    logic [9:0] rawWord;
    logic [7:0] dataOut;
    logic       c0, c1, de, locked;
    logic [3:0] slipPos, terc4;
    logic       terc4Valid;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    // serializer phase emulation
    int         off = 0;
    logic [9:0] last_word = '0;

    // reference model state and expected outputs
    logic [9:0] m_prev = '0;
    logic [9:0] m_s1 = '0;
    int m_mode = M_SEARCH;
    int m_timer = 0;
    int m_cnt = 0;
    int m_settle = 0;
    int m_slip = 0;
    logic [7:0] e_data = '0;
    logic       e_c0 = 1'b0, e_c1 = 1'b0, e_de = 1'b0, e_locked = 1'b0;
    logic [3:0] e_slip = '0, e_t4 = '0;
    logic       e_t4v = 1'b0;

    tmds_decoder #(.SEARCH_BITS(SEARCH_BITS), .LOCK_COUNT(LOCK_COUNT)) dut (
        .clkPixel  (clkPixel),
        .nreset    (nreset),
        .rawWord   (rawWord),
        .dataOut   (dataOut),
        .c0        (c0),
        .c1        (c1),
        .de        (de),
        .locked    (locked),
        .slipPos   (slipPos),
        .terc4     (terc4),
        .terc4Valid(terc4Valid)
    );

    always #5 clkPixel = ~clkPixel;

    function automatic int ref_token(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    // d[i] = q[i]^q[i-1] (or its complement), d[0] = q[0]
    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] q, x;
        q = w[9] ? ~w[7:0] : w[7:0];
        x = q ^ {q[6:0], 1'b0};
        if (!w[8]) x = ~x;
        x[0] = q[0];
        return x;
    endfunction

`ifdef TMDS_DEC_TERC4_EN
    function automatic int ref_terc4(input logic [9:0] w);
        logic [9:0] tbl [16];
        tbl[0]  = 10'b1010011100; tbl[1]  = 10'b1001100011;
        tbl[2]  = 10'b1011100100; tbl[3]  = 10'b1011100010;
        tbl[4]  = 10'b0101110001; tbl[5]  = 10'b0100011110;
        tbl[6]  = 10'b0110001110; tbl[7]  = 10'b0100111100;
        tbl[8]  = 10'b1011001100; tbl[9]  = 10'b0100111001;
        tbl[10] = 10'b0110011100; tbl[11] = 10'b1011000110;
        tbl[12] = 10'b1010001110; tbl[13] = 10'b1001110001;
        tbl[14] = 10'b0101100011; tbl[15] = 10'b1011000011;
        for (int k = 0; k < 16; k++) if (tbl[k] == w) return k;
        return -1;
    endfunction
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one aligned word consumed per clock
    initial begin : ref_model
        logic [19:0] win;
        logic [9:0]  w;
        int          tv;
        int          t4;
        bit          step;
        forever begin
            @(posedge clkPixel or negedge nreset);
            if (!nreset) begin
                m_prev = '0; m_s1 = '0; m_mode = M_SEARCH; m_timer = 0;
                m_cnt = 0; m_settle = 0; m_slip = 0;
                e_data = '0; e_c0 = 0; e_c1 = 0; e_de = 0; e_locked = 0;
                e_slip = '0; e_t4 = '0; e_t4v = 0;
            end else begin
                w    = m_s1;
                tv   = ref_token(w);
                step = 1'b0;
                if (m_settle > 0) begin
                    m_settle--;
                end else if (m_mode == M_SEARCH) begin
                    if (tv >= 0) begin
                        m_cnt = 1; m_timer = 0;
                        m_mode = (m_cnt >= LOCK_COUNT) ? M_LOCKED : M_VERIFY;
                    end else begin
                        m_timer++;
                        if (m_timer == TIMEOUT) begin m_timer = 0; step = 1'b1; end
                    end
                end else if (m_mode == M_VERIFY) begin
                    if (tv >= 0) begin
                        m_cnt++;
                        if (m_cnt >= LOCK_COUNT) m_mode = M_LOCKED;
                    end else begin
                        m_mode = M_SEARCH; m_timer = 0;
                    end
                end else begin
                    if (tv >= 0) m_timer = 0;
                    else begin
                        m_timer++;
                        if (m_timer == TIMEOUT) begin
                            m_timer = 0; m_mode = M_SEARCH; step = 1'b1;
                        end
                    end
                end
                win    = {rawWord, m_prev};
                m_s1   = win[m_slip +: 10];
                m_prev = rawWord;
                if (step) begin m_slip = (m_slip + 1) % 10; m_settle = 2; end
                if (m_mode == M_LOCKED) begin
                    if (tv >= 0) begin e_de = 0; e_c1 = tv[1]; e_c0 = tv[0]; end
                    else begin e_de = 1; e_data = ref_decode(w); end
                end else begin
                    e_de = 0; e_data = '0; e_c0 = 0; e_c1 = 0;
                end
                e_locked = (m_mode == M_LOCKED);
                e_slip   = 4'(m_slip);
`ifdef TMDS_DEC_TERC4_EN
                t4    = ref_terc4(w);
                e_t4v = (t4 >= 0);
                e_t4  = (t4 >= 0) ? 4'(t4) : 4'd0;
`else
                t4    = -1;
                e_t4v = 1'b0;
                e_t4  = 4'd0;
`endif
            end
        end
    end

    // Compare process: every negedge against the model
    initial begin : compare
        forever begin
            @(negedge clkPixel);
            if (check_en) begin
                chk("cyc dataOut",    32'(dataOut),    32'(e_data));
                chk("cyc c0",         32'(c0),         32'(e_c0));
                chk("cyc c1",         32'(c1),         32'(e_c1));
                chk("cyc de",         32'(de),         32'(e_de));
                chk("cyc locked",     32'(locked),     32'(e_locked));
                chk("cyc slipPos",    32'(slipPos),    32'(e_slip));
                chk("cyc terc4",      32'(terc4),      32'(e_t4));
                chk("cyc terc4Valid", 32'(terc4Valid), 32'(e_t4v));
            end
        end
    end

    // Present one word of the serial stream, shifted by the current phase
    task automatic send_word(input logic [9:0] w);
        logic [19:0] pair;
        @(negedge clkPixel);
        pair      = {w, last_word};
        rawWord   = pair[(10 - off) +: 10];
        last_word = w;
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (ref_token(w) >= 0);
        return w;
    endfunction

    function automatic logic [9:0] rand_token();
        logic [9:0] t;
        case ($urandom_range(0, 3))
            0: t = 10'h354;
            1: t = 10'h0AB;
            2: t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    task automatic run_until_lock(input logic [9:0] w, input int budget, input string tag);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < budget) begin
            send_word(w);
            n++;
        end
        chk({tag, " lock reached"}, 32'(locked), 32'd1);
    endtask

    // Asynchronous reset pulse away from the clock edge
    task automatic do_reset();
        @(negedge clkPixel);
        #2;
        nreset    = 1'b0;
        rawWord   = '0;
        last_word = '0;
        #1;
        chk("async rst locked",  32'(locked),  32'd0);
        chk("async rst slipPos", 32'(slipPos), 32'd0);
        chk("async rst de",      32'(de),      32'd0);
        repeat (3) @(negedge clkPixel);
        nreset = 1'b1;
    endtask

    initial begin : stimulus
        nreset  = 1'b0;
        rawWord = '0;
        @(negedge clkPixel);
        check_en = 1'b1;

        // reset held with random input
        for (int i = 0; i < 8; i++) begin
            @(negedge clkPixel);
            rawWord = 10'($urandom);
            chk("reset dataOut", 32'(dataOut), 32'd0);
            chk("reset locked",  32'(locked),  32'd0);
            chk("reset slipPos", 32'(slipPos), 32'd0);
            chk("reset terc4V",  32'(terc4Valid), 32'd0);
        end
        @(negedge clkPixel);
        rawWord = '0;
        nreset  = 1'b1;
        @(negedge clkPixel);
        chk("release locked",  32'(locked),  32'd0);
        chk("release slipPos", 32'(slipPos), 32'd0);

        // search and lock on a token stream rotated by 3
        off = 3;
        run_until_lock(10'h354, 15000, "rot3");
        chk("rot3 slipPos", 32'(slipPos), 32'd3);
        chk("rot3 c1c0",    32'({c1, c0}), 32'd0);
        chk("rot3 de",      32'(de), 32'd0);

        // mid-operation reset, then lock at slip 0 with exact token count
        do_reset();
        off = 0;
        repeat (34) send_word(10'h354);
        chk("slip0 locked early", 32'(locked), 32'd0);
        send_word(10'h354);
        chk("slip0 locked on 32nd", 32'(locked), 32'd1);
        chk("slip0 slipPos", 32'(slipPos), 32'd0);

        // data decode
        send_word(10'b1011111111);
        send_word(10'b0100000000);
        send_word(10'h354);
        send_word(10'h354);
        chk("data FE dataOut", 32'(dataOut), 32'hFE);
        chk("data FE de",      32'(de),      32'd1);
        send_word(10'h354);
        chk("data 00 dataOut", 32'(dataOut), 32'h00);
        chk("data 00 de",      32'(de),      32'd1);
        send_word(10'h354);
        chk("token de",        32'(de),      32'd0);
        chk("token hold data", 32'(dataOut), 32'h00);
        chk("token c1c0",      32'({c1, c0}), 32'd0);

        // other control tokens
        repeat (4) send_word(10'h0AB);
        chk("tok01 c1c0", 32'({c1, c0}), 32'd1);
        repeat (4) send_word(10'h154);
        chk("tok10 c1c0", 32'({c1, c0}), 32'd2);

        // TERC4 code word
        send_word(10'b1010011100);
        send_word(10'h354);
        send_word(10'h354);
        send_word(10'h354);
        chk("terc4 word dataOut", 32'(dataOut), 32'h5B);
`ifdef TMDS_DEC_TERC4_EN
        chk("terc4 valid", 32'(terc4Valid), 32'd1);
        chk("terc4 value", 32'(terc4),      32'd0);
`else
        chk("terc4 disabled", 32'(terc4Valid), 32'd0);
`endif
        repeat (4) send_word(10'h354);

        // loss of lock: token as the 4096th word keeps lock
        repeat (4095) send_word(rand_data());
        send_word(10'h354);
        repeat (4) send_word(10'h354);
        chk("keep lock", 32'(locked), 32'd1);
        repeat (4096) send_word(rand_data());
        repeat (2) send_word(rand_data());
        chk("before loss locked", 32'(locked), 32'd1);
        send_word(rand_data());
        chk("loss locked",  32'(locked),  32'd0);
        chk("loss slipPos", 32'(slipPos), 32'd1);

        // VERIFY abort after 10 tokens
        do_reset();
        off = 0;
        repeat (10) send_word(10'h354);
        send_word(rand_data());
        repeat (34) send_word(10'h354);
        chk("abort locked",  32'(locked),  32'd0);
        chk("abort slipPos", 32'(slipPos), 32'd0);
        send_word(10'h354);
        chk("abort relock", 32'(locked), 32'd1);

        // randomized phase and mixed token stream
        do_reset();
        off = $urandom_range(1, 3);
        begin
            int n;
            n = 0;
            while (locked !== 1'b1 && n < 20000) begin
                send_word(($urandom_range(0, 31) == 0) ? rand_data() : rand_token());
                n++;
            end
            chk("random lock reached", 32'(locked), 32'd1);
        end
        for (int i = 0; i < 600; i++) begin
            send_word(($urandom_range(0, 1) == 0) ? rand_data() : rand_token());
        end

        @(negedge clkPixel);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
